spi_sar_adc: RTL and testbench
==============================

Name: spi_sar_adc

Overview:
- SPI-slave-controlled 12-bit successive-approximation ADC controller.
- Contains a 4-register map, accessed through a 16-bit SPI mode-0 frame.
- Contains the SAR sequencer, which drives an external DAC and sample-and-hold and reads an external comparator.
- Generates a divided ADC clock for 8 ksps or 16 ksps conversion rates; raises an interrupt at end of conversion.

Parameters:
- SYS_CLK_FREQ, 50_000_000: system clock frequency in Hz; sets the ADC clock dividers.
- ADC_WIDTH, 12: result and DAC width. Register data width is fixed at 12.

Ports:
- sys_clk  in  1  system clock. The only clock; all logic is on the rising edge.
- reset_  in  1  asynchronous, active-low reset.
- cs  in  1  SPI chip select, active low. Asynchronous to sys_clk.
- sck  in  1  SPI clock, mode 0. Asynchronous to sys_clk.
- mosi  in  1  SPI data in.
- miso  out  1  SPI data out.
- comparator  in  1  1 when analog input >= DAC voltage.
- dac  out  ADC_WIDTH  SAR trial code.
- sample_and_hold  out  1  high during the sample phase.
- pwr_gate  out  1  analog power enable; equals CTRL.ADC_EN.
- dac_rst  out  1  high during the sample phase only.
- irq  out  1  level interrupt.
- vref_sel  out  1  equals CTRL.VREF.
- adc_clk_out  out  1  divided ADC clock.

Behaviour:
- Reset values: every output, CTRL, DATA, EOC and all state are 0; FSM is IDLE.

SPI interface:
- cs, sck and mosi each pass through a 2-FF synchronizer into sys_clk, followed by edge detection.
- Frame is 16 bits, MSB first, mosi sampled on sck rising edge: {cmd[1:0], addr[1:0], data[11:0]}.
- cmd bit14 = 1 means write; otherwise the frame is a read.
- Falling cs resets the bit counter. Frames shorter than 16 bits are discarded.
- Write: the target register updates after the 16th sck rising edge.
- Read: after the 4th rising edge, the addressed register is loaded into the TX shifter. miso updates on sck falling edges, so bit11 is valid before the 5th rising edge and bit0 before the 16th.
- miso is 0 during the header bits and while cs is high.

Register map:
- 0 CTRL, RW, 12 bits stored:
  - b0 ADC_EN
  - b1 START (self-clearing when a conversion begins)
  - b2 AUTO
  - b3 VREF
  - b4 INT_EN
  - b6 CLK_SEL (0 = 8 ksps, 1 = 16 ksps)
  - all other bits are plain storage
  - Example: write 0x5A5 reads back as 0x5A5.
- 1 STATUS, RO: b0 EOC, b1 BUSY, other bits 0. A completed read of STATUS clears EOC and irq.
- 2 DATA, RO: last conversion result.
- 3 INFO, RO: constant 0x00A.

ADC clock:
- DIV = SYS_CLK_FREQ / (rate × 14 × 2), integer division. At 50 MHz: 223 for 8 ksps, 111 for 16 ksps.
- adc_clk_out toggles every DIV sys_clk cycles while ADC_EN = 1; it is held 0 otherwise.
- A "tick" is the adc_clk_out rising edge. The divider restarts when a conversion is launched from IDLE.

FSM states: IDLE, SAMPLE, CONV, DONE.
- IDLE → SAMPLE when ADC_EN && (START || AUTO). START is cleared at this transition.
- SAMPLE: sample_and_hold = 1, dac_rst = 1, dac = 0. On tick → CONV with bit index 11 and dac = 0x800.
- CONV, on each tick:
  - keep the current trial bit if comparator = 1, else clear it;
  - set the next lower bit;
  - after bit0 → DONE.
  - This state spans 12 ticks.
- DONE, on tick:
  - DATA ← result; EOC ← 1; irq ← 1 if INT_EN.
  - Go to SAMPLE if AUTO && ADC_EN, else IDLE.
- A conversion is 14 ticks: about 125 µs at 8 ksps, about 62.5 µs at 16 ksps.
- BUSY = (state != IDLE).
- ADC_EN cleared at any time: abort to IDLE immediately; DATA and EOC are kept.
- Simultaneous STATUS-read clear and DONE set: the set wins.
- In AUTO mode, DATA is overwritten each conversion whether or not EOC was cleared.
- A CLK_SEL change takes effect at the next launch.

Test Plan:
- After reset: read CTRL → 0x000; read INFO → 0x00A. Write CTRL 0x5A5 → readback 0x5A5. Write CTRL 0x008 → vref_sel = 1.
- Input 0xA52, write CTRL 0x013: irq rises 110–130 µs after the frame; DATA = 0xA52; CTRL.START reads 0.
- Corners: input 0x000 → DATA 0x000; input 0xFFF → DATA 0xFFF. 25 µs after a start, STATUS.BUSY = 1.
- Write CTRL 0x003 (INT_EN off): after 200 µs, irq = 0 and STATUS.EOC = 1. Reading STATUS clears EOC and irq.
- CTRL 0x053 with input 0x888: irq within 55–75 µs, DATA = 0x888. Then CTRL 0x013 with input 0x111: 110–130 µs, DATA = 0x111.
- AUTO mode, write CTRL 0x045:
  - poll EOC → DATA 0x200;
  - change input to 0x999, discard one result;
  - next result → 0x999.
  - Then write CTRL 0: pwr_gate = 0, dac_rst = 0, adc_clk_out = 0.

Source files
------------

// File: rtl/spi_sar_adc.sv
// SPI-slave-controlled successive-approximation ADC sequencer with a 4-entry register map,
// divided ADC clock and end-of-conversion interrupt.
//
// state  | meaning
// IDLE   | waiting for ADC_EN && (START || AUTO)
// SAMPLE | sample-and-hold open, DAC held in reset
// CONV   | one trial bit resolved per ADC tick, MSB first
// DONE   | result published on the next tick
module spi_sar_adc #(
    parameter int SYS_CLK_FREQ = 50_000_000,
    parameter int ADC_WIDTH    = 12
) (
    input  logic                 sys_clk,
    input  logic                 reset_,
    input  logic                 cs,
    input  logic                 sck,
    input  logic                 mosi,
    output logic                 miso,
    input  logic                 comparator,
    output logic [ADC_WIDTH-1:0] dac,
    output logic                 sample_and_hold,
    output logic                 pwr_gate,
    output logic                 dac_rst,
    output logic                 irq,
    output logic                 vref_sel,
    output logic                 adc_clk_out
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SAMPLE = 2'd1;
    localparam logic [1:0] CONV   = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    localparam int DIV_SLOW = SYS_CLK_FREQ / (8000 * 28);
    localparam int DIV_FAST = SYS_CLK_FREQ / (16000 * 28);
    localparam int DW       = $clog2(DIV_SLOW + 1);
    localparam int IW       = $clog2(ADC_WIDTH);

    logic [2:0]  cs_sync, sck_sync;
    logic [1:0]  mosi_sync;
    logic        cs_high, cs_fall, sck_rise, sck_fall, mosi_b;
    logic [4:0]  bit_cnt;
    logic [13:0] rx_sh;
    logic [11:0] tx_sh;
    logic        tx_en, miso_r;
    logic        frame_done, wr_en, rd_status;
    logic [1:0]  rd_addr;
    logic [11:0] rd_data;

    logic [11:0]          ctrl;
    logic [ADC_WIDTH-1:0] data_r, dac_r;
    logic                 eoc, irq_r;
    logic [1:0]           state;
    logic [IW-1:0]        bit_idx;
    logic [DW-1:0]        div_cnt, div_reload;
    logic                 div_sel, adc_clk;
    logic                 launch, tick, done_set;

    always_ff @(posedge sys_clk or negedge reset_) begin
        if (!reset_) begin
            cs_sync   <= '0;
            sck_sync  <= '0;
            mosi_sync <= '0;
        end else begin
            cs_sync   <= {cs_sync[1:0], cs};
            sck_sync  <= {sck_sync[1:0], sck};
            mosi_sync <= {mosi_sync[0], mosi};
        end
    end

    assign cs_high  = cs_sync[1];
    assign cs_fall  = ~cs_sync[1] & cs_sync[2];
    assign sck_rise = sck_sync[1] & ~sck_sync[2];
    assign sck_fall = ~sck_sync[1] & sck_sync[2];
    assign mosi_b   = mosi_sync[1];

    // rx_sh drops the oldest bit, so at the 16th edge it holds frame bits 14..1.
    assign frame_done = ~cs_high & sck_rise & (bit_cnt == 5'd15);
    assign wr_en      = frame_done & rx_sh[13];
    assign rd_status  = frame_done & ~rx_sh[13] & (rx_sh[12:11] == 2'd1);
    assign rd_addr    = {rx_sh[0], mosi_b};

    always_comb begin
        rd_data = 12'h000;
        case (rd_addr)
            2'd0: rd_data = ctrl;
            2'd1: rd_data = {10'b0, (state != IDLE), eoc};
            2'd2: rd_data = 12'(data_r);
            2'd3: rd_data = 12'h00A;
            default: rd_data = 12'h000;
        endcase
    end

    always_ff @(posedge sys_clk or negedge reset_) begin
        if (!reset_) begin
            bit_cnt <= '0;
            rx_sh   <= '0;
            tx_sh   <= '0;
            tx_en   <= 1'b0;
            miso_r  <= 1'b0;
        end else if (cs_high || cs_fall) begin
            bit_cnt <= '0;
            tx_en   <= 1'b0;
            miso_r  <= 1'b0;
        end else begin
            if (sck_rise && bit_cnt != 5'd16) begin
                rx_sh   <= {rx_sh[12:0], mosi_b};
                bit_cnt <= bit_cnt + 5'd1;
                if (bit_cnt == 5'd3) begin
                    tx_sh <= rd_data;
                    tx_en <= 1'b1;
                end
            end
            if (sck_fall && tx_en) begin
                miso_r <= tx_sh[11];
                tx_sh  <= {tx_sh[10:0], 1'b0};
            end
        end
    end

    assign launch = (state == IDLE) & ctrl[0] & (ctrl[1] | ctrl[2]);

    always_ff @(posedge sys_clk or negedge reset_) begin
        if (!reset_)
            ctrl <= '0;
        else if (wr_en && rx_sh[12:11] == 2'd0)
            ctrl <= {rx_sh[10:0], mosi_b};
        else if (launch)
            ctrl[1] <= 1'b0;
    end

    assign div_reload = div_sel ? DW'(DIV_FAST - 1) : DW'(DIV_SLOW - 1);
    assign tick       = ctrl[0] & ~launch & (div_cnt == '0) & ~adc_clk;

    always_ff @(posedge sys_clk or negedge reset_) begin
        if (!reset_) begin
            div_cnt <= '0;
            div_sel <= 1'b0;
            adc_clk <= 1'b0;
        end else if (!ctrl[0]) begin
            div_cnt <= div_reload;
            adc_clk <= 1'b0;
        end else if (launch) begin
            div_sel <= ctrl[6];
            div_cnt <= ctrl[6] ? DW'(DIV_FAST - 1) : DW'(DIV_SLOW - 1);
            adc_clk <= 1'b0;
        end else if (div_cnt == '0) begin
            div_cnt <= div_reload;
            adc_clk <= ~adc_clk;
        end else begin
            div_cnt <= div_cnt - 1'b1;
        end
    end

    always_ff @(posedge sys_clk or negedge reset_) begin
        if (!reset_) begin
            state   <= IDLE;
            bit_idx <= '0;
            dac_r   <= '0;
        end else if (!ctrl[0]) begin
            state <= IDLE;
            dac_r <= '0;
        end else begin
            case (state)
                IDLE: if (launch) begin
                    state <= SAMPLE;
                    dac_r <= '0;
                end
                SAMPLE: if (tick) begin
                    state   <= CONV;
                    bit_idx <= IW'(ADC_WIDTH - 1);
                    dac_r   <= {1'b1, {(ADC_WIDTH-1){1'b0}}};
                end
                CONV: if (tick) begin
                    dac_r[bit_idx] <= comparator;
                    if (bit_idx == '0) begin
                        state <= DONE;
                    end else begin
                        dac_r[bit_idx - 1'b1] <= 1'b1;
                        bit_idx <= bit_idx - 1'b1;
                    end
                end
                DONE: if (tick) begin
                    state <= ctrl[2] ? SAMPLE : IDLE;
                    if (ctrl[2])
                        dac_r <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A result landing in the same cycle as a STATUS-read clear takes priority.
    assign done_set = (state == DONE) & tick;

    always_ff @(posedge sys_clk or negedge reset_) begin
        if (!reset_) begin
            data_r <= '0;
            eoc    <= 1'b0;
            irq_r  <= 1'b0;
        end else begin
            if (done_set)
                data_r <= dac_r;
            if (done_set)
                eoc <= 1'b1;
            else if (rd_status)
                eoc <= 1'b0;
            if (done_set && ctrl[4])
                irq_r <= 1'b1;
            else if (rd_status)
                irq_r <= 1'b0;
        end
    end

    assign miso            = miso_r;
    assign dac             = dac_r;
    assign sample_and_hold = (state == SAMPLE);
    assign dac_rst         = (state == SAMPLE);
    assign pwr_gate        = ctrl[0];
    assign vref_sel        = ctrl[3];
    assign irq             = irq_r;
    assign adc_clk_out     = adc_clk;
endmodule

// File: tb/tb_spi_sar_adc.sv
// Directed bench for spi_sar_adc: SPI register access plus full conversions against an
// ideal comparator model (vin >= dac).
`timescale 1ns/1ps
module tb_spi_sar_adc;
    localparam int HALF = 160;

    logic        sys_clk = 1'b0;
    logic        reset_;
    logic        cs, sck, mosi;
    logic        miso, comparator;
    logic [11:0] dac;
    logic        sample_and_hold, pwr_gate, dac_rst, irq, vref_sel, adc_clk_out;
    logic [11:0] vin;

    int checks   = 0;
    int failures = 0;

    always #10 sys_clk = ~sys_clk;

    assign comparator = (vin >= dac);

    spi_sar_adc #(.SYS_CLK_FREQ(50_000_000), .ADC_WIDTH(12)) dut (
        .sys_clk(sys_clk), .reset_(reset_), .cs(cs), .sck(sck), .mosi(mosi), .miso(miso),
        .comparator(comparator), .dac(dac), .sample_and_hold(sample_and_hold),
        .pwr_gate(pwr_gate), .dac_rst(dac_rst), .irq(irq), .vref_sel(vref_sel),
        .adc_clk_out(adc_clk_out)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic spi_xfer(input logic [15:0] tx, output logic [15:0] rx);
        rx = '0;
        cs = 1'b0;
        #(2*HALF);
        for (int i = 0; i < 16; i++) begin
            mosi = tx[15-i];
            #HALF;
            rx[15-i] = miso;
            sck = 1'b1;
            #HALF;
            sck = 1'b0;
        end
        #HALF;
        cs   = 1'b1;
        mosi = 1'b0;
        #(2*HALF);
    endtask

    task automatic wr(input logic [1:0] addr, input logic [11:0] data);
        logic [15:0] dummy;
        spi_xfer({2'b01, addr, data}, dummy);
    endtask

    task automatic rd(input logic [1:0] addr, output logic [15:0] frame);
        spi_xfer({2'b00, addr, 12'h000}, frame);
    endtask

    task automatic wait_irq(input real bound_us, output real elapsed_us);
        realtime t0;
        t0 = $realtime;
        while (!irq && ($realtime - t0) < bound_us * 1000.0)
            #100;
        elapsed_us = ($realtime - t0) / 1000.0;
    endtask

    task automatic poll_eoc(input int max_polls, output logic seen);
        logic [15:0] s;
        seen = 1'b0;
        for (int p = 0; p < max_polls && !seen; p++) begin
            rd(2'd1, s);
            seen = s[0];
        end
    endtask

    initial begin
        logic [15:0] r;
        real         t;
        logic        seen;

        reset_ = 1'b0; cs = 1'b1; sck = 1'b0; mosi = 1'b0; vin = 12'h000;
        #100;
        check("reset_outputs",
              {4'h0, miso, dac, sample_and_hold, pwr_gate, dac_rst, irq, vref_sel, adc_clk_out}, '0);
        reset_ = 1'b1;
        #200;

        rd(2'd0, r);  check("ctrl_reset", r[11:0], 12'h000);
        rd(2'd3, r);  check("info", r[11:0], 12'h00A);
        check("miso_header_zero", r[15:12], 4'h0);

        wr(2'd0, 12'h5A5);
        rd(2'd0, r);  check("ctrl_rw", r[11:0], 12'h5A5);
        wr(2'd0, 12'h008);
        check("vref_sel", vref_sel, 1'b1);
        check("pwr_gate_off", pwr_gate, 1'b0);
        rd(2'd1, r);  check("status_after_abort", r[11:0], 12'h000);

        // 8 ksps conversion with interrupt
        vin = 12'hA52;
        wr(2'd0, 12'h013);
        wait_irq(200.0, t);
        check("irq_time_8k_a52", (t >= 110.0 && t <= 130.0), 1'b1);
        rd(2'd2, r);  check("data_a52", r[11:0], 12'hA52);
        rd(2'd0, r);  check("start_self_clear", r[11:0], 12'h011);
        check("irq_held", irq, 1'b1);
        rd(2'd1, r);  check("status_eoc", r[11:0], 12'h001);
        check("irq_cleared", irq, 1'b0);
        rd(2'd1, r);  check("status_cleared", r[11:0], 12'h000);

        vin = 12'h000;
        wr(2'd0, 12'h013);
        check("sample_phase", {sample_and_hold, dac_rst, adc_clk_out, dac}, {1'b1, 1'b1, 1'b0, 12'h000});
        wait_irq(200.0, t);
        check("irq_seen_000", irq, 1'b1);
        rd(2'd2, r);  check("data_000", r[11:0], 12'h000);
        rd(2'd1, r);  check("status_000", r[11:0], 12'h001);

        vin = 12'hFFF;
        wr(2'd0, 12'h013);
        #20000;
        rd(2'd1, r);  check("busy_mid_conv", r[11:0], 12'h002);
        wait_irq(200.0, t);
        check("irq_seen_fff", irq, 1'b1);
        rd(2'd2, r);  check("data_fff", r[11:0], 12'hFFF);
        rd(2'd1, r);  check("status_fff", r[11:0], 12'h001);

        // interrupt disabled: EOC still reports completion
        vin = 12'h123;
        wr(2'd0, 12'h003);
        #200000;
        check("irq_disabled", irq, 1'b0);
        rd(2'd1, r);  check("eoc_no_int", r[11:0], 12'h001);
        rd(2'd1, r);  check("eoc_cleared", r[11:0], 12'h000);
        rd(2'd2, r);  check("data_123", r[11:0], 12'h123);

        // 16 ksps, then back to 8 ksps
        vin = 12'h888;
        wr(2'd0, 12'h053);
        wait_irq(150.0, t);
        check("irq_time_16k", (t >= 55.0 && t <= 75.0), 1'b1);
        rd(2'd2, r);  check("data_888", r[11:0], 12'h888);
        rd(2'd1, r);
        vin = 12'h111;
        wr(2'd0, 12'h013);
        wait_irq(200.0, t);
        check("irq_time_8k_111", (t >= 110.0 && t <= 130.0), 1'b1);
        rd(2'd2, r);  check("data_111", r[11:0], 12'h111);
        rd(2'd1, r);

        // continuous conversions
        vin = 12'h200;
        wr(2'd0, 12'h045);
        poll_eoc(60, seen);
        check("auto_eoc_1", seen, 1'b1);
        rd(2'd2, r);  check("auto_data_200", r[11:0], 12'h200);
        vin = 12'h999;
        poll_eoc(60, seen);
        check("auto_eoc_discard", seen, 1'b1);
        poll_eoc(60, seen);
        check("auto_eoc_2", seen, 1'b1);
        rd(2'd2, r);  check("auto_data_999", r[11:0], 12'h999);

        wr(2'd0, 12'h000);
        check("stop_outputs", {pwr_gate, dac_rst, adc_clk_out, sample_and_hold}, 4'h0);
        rd(2'd1, r);  check("stop_not_busy", r[1], 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
